// File: rtl/imem_loadable.sv
// Loadable instruction memory: cleared after reset, filled from an MSB-first byte stream, read with one-cycle latency.
// Define IMEM_PARITY_EN to store a per-word even-parity bit and report read parity errors on PERR.
module imem_loadable #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DEPTH  = 128
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [ADDR_W-1:0] ADDR,
    output logic [DATA_W-1:0] Q,
    output logic              MISALIGN,
    output logic              PERR,
    input  logic              LD_START,
    input  logic              LD_VALID,
    input  logic [7:0]        LD_BYTE,
    input  logic              LD_LAST,
    output logic              LD_READY,
    output logic              BUSY,
    output logic              OVF
);
    localparam int unsigned BPW   = DATA_W / 8;
    localparam int unsigned LSB   = $clog2(BPW);
    localparam int unsigned IDX_W = ADDR_W - LSB;
    localparam int unsigned MA_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PTR_W = $clog2(DEPTH + 1);
    localparam int unsigned CNT_W = $clog2(BPW + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0] PTR_FULL = PTR_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BPW - 1);
    localparam logic [IDX_W:0]   IDX_LIM  = (IDX_W + 1)'(DEPTH);
`ifdef IMEM_PARITY_EN
    localparam int unsigned MEM_W = DATA_W + 1;
`else
    localparam int unsigned MEM_W = DATA_W;
`endif

    typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_LOAD} state_t;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    ptr_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [DATA_W-9:0]   asm_q;
    logic                ovf_q;

    logic [MEM_W-1:0]    mem [DEPTH];

    logic                accept, drop, take, word_done;
    logic [DATA_W-1:0]   shifted, fill_word;
    logic                wr_en;
    logic [MA_W-1:0]     wr_addr;
    logic [DATA_W-1:0]   wr_data;

    logic [IDX_W-1:0]    rd_idx;
    logic                rd_ok;
    logic [MEM_W-1:0]    rd_word;

    // LD_START wins over a byte presented in the same cycle
    assign accept    = (state_q == S_LOAD) && LD_VALID && !LD_START;
    assign drop      = accept && (ptr_q == PTR_FULL);
    assign take      = accept && !drop;
    assign shifted   = {asm_q, LD_BYTE};
    assign word_done = take && ((cnt_q == CNT_LAST) || LD_LAST);
    // Left-justify a short final word; older bytes fall off the top
    assign fill_word = shifted << {CNT_LAST - cnt_q, 3'b000};

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state_q <= S_CLEAR;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_CLEAR: if (ptr_q == PTR_LAST) state_d = S_IDLE;
            S_IDLE:  if (LD_START) state_d = S_LOAD;
            S_LOAD:  if (accept && LD_LAST) state_d = S_IDLE;
            default: state_d = S_CLEAR;
        endcase
    end

    always_comb begin
        LD_READY = (state_q == S_LOAD);
        BUSY     = (state_q != S_IDLE);
        wr_en    = 1'b0;
        wr_addr  = ptr_q[MA_W-1:0];
        wr_data  = '0;
        if (state_q == S_CLEAR) begin
            wr_en = 1'b1;
        end else if (state_q == S_LOAD) begin
            wr_en   = word_done;
            wr_data = fill_word;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ptr_q <= '0;
            cnt_q <= '0;
            asm_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_CLEAR: ptr_q <= (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
                S_IDLE: begin
                    if (LD_START) begin
                        ptr_q <= '0;
                        cnt_q <= '0;
                        asm_q <= '0;
                        ovf_q <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (LD_START) begin
                        ptr_q <= '0;
                        cnt_q <= '0;
                        asm_q <= '0;
                        ovf_q <= 1'b0;
                    end else if (drop) begin
                        ovf_q <= 1'b1;
                    end else if (take) begin
                        asm_q <= shifted[DATA_W-9:0];
                        if (word_done) begin
                            ptr_q <= ptr_q + 1'b1;
                            cnt_q <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign OVF = ovf_q;

    always_ff @(posedge CLK) begin
        if (wr_en) begin
`ifdef IMEM_PARITY_EN
            mem[wr_addr] <= {^wr_data, wr_data};
`else
            mem[wr_addr] <= wr_data;
`endif
        end
    end

    assign rd_idx  = ADDR[ADDR_W-1:LSB];
    assign rd_ok   = (state_q == S_IDLE) && ({1'b0, rd_idx} < IDX_LIM);
    assign rd_word = mem[rd_idx[MA_W-1:0]];

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            Q        <= '0;
            MISALIGN <= 1'b0;
            PERR     <= 1'b0;
        end else begin
            Q        <= rd_ok ? rd_word[DATA_W-1:0] : '0;
            MISALIGN <= |ADDR[LSB-1:0];
`ifdef IMEM_PARITY_EN
            PERR     <= rd_ok && (rd_word[DATA_W] != ^rd_word[DATA_W-1:0]);
`else
            PERR     <= 1'b0;
`endif
        end
    end
endmodule

// File: tb/tb_imem_loadable.sv
// Randomised bench for imem_loadable against a byte-list-to-word reference model.
// Build with IMEM_PARITY_EN defined to include the parity corruption check.
module tb_imem_loadable;
    localparam int unsigned DEPTH = 64;

    typedef logic [7:0] byte_q_t [$];

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic [7:0]  ADDR = 8'h10;
    logic [15:0] Q;
    logic        MISALIGN, PERR;
    logic        LD_START = 1'b0, LD_VALID = 1'b0, LD_LAST = 1'b0;
    logic [7:0]  LD_BYTE = 8'h00;
    logic        LD_READY, BUSY, OVF;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic [15:0] model_mem [DEPTH];
    logic        model_ovf = 1'b0;

    imem_loadable #(.DATA_W(16), .ADDR_W(8), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .ADDR(ADDR), .Q(Q), .MISALIGN(MISALIGN), .PERR(PERR),
        .LD_START(LD_START), .LD_VALID(LD_VALID), .LD_BYTE(LD_BYTE), .LD_LAST(LD_LAST),
        .LD_READY(LD_READY), .BUSY(BUSY), .OVF(OVF)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model_clear();
        for (int k = 0; k < DEPTH; k++) model_mem[k] = 16'h0000;
        model_ovf = 1'b0;
    endfunction

    // Word k is bytes 2k (MSB) and 2k+1; a missing low byte reads as zero; excess bytes are dropped
    function automatic void model_load(input byte_q_t b);
        int unsigned n = b.size();
        for (int k = 0; k < DEPTH; k++) begin
            if (2 * k < n) model_mem[k] = {b[2*k], (2 * k + 1 < n) ? b[2*k+1] : 8'h00};
        end
        model_ovf = (n > 2 * DEPTH);
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // gap_mode: 0 none, 1 random 0..3 idle cycles, 2 five idle cycles before every odd byte
    task automatic do_load(input byte_q_t b, input int unsigned gap_mode);
        int unsigned gap;
        LD_START = 1'b1;
        tick();
        LD_START = 1'b0;
        check_eq("ld_ready_load", LD_READY, 1);
        check_eq("ovf_after_start", OVF, 0);
        foreach (b[i]) begin
            gap = (gap_mode == 1) ? $urandom_range(0, 3) : ((gap_mode == 2 && i % 2 == 1) ? 5 : 0);
            LD_VALID = 1'b0;
            repeat (gap) tick();
            LD_VALID = 1'b1;
            LD_BYTE  = b[i];
            LD_LAST  = (i == b.size() - 1);
            tick();
        end
        LD_VALID = 1'b0;
        LD_LAST  = 1'b0;
        tick();
        tick();
        model_load(b);
    endtask

    task automatic read_expect(input string tag, input logic [7:0] a, input logic [15:0] exp_q, input logic exp_mis);
        ADDR = a;
        tick();
        check_eq(tag, Q, exp_q);
        check_eq("misalign", MISALIGN, exp_mis);
        check_eq("perr_clean", PERR, 0);
    endtask

    task automatic read_model(input logic [7:0] a);
        int unsigned idx = a / 2;
        read_expect("q_model", a, (idx < DEPTH) ? model_mem[idx] : 16'h0000, a[0]);
    endtask

    task automatic wait_clear();
        for (int i = 1; i <= DEPTH; i++) begin
            LD_START = (i == 10);
            tick();
            check_eq("busy_clear", BUSY, (i < DEPTH) ? 1 : 0);
            check_eq("q_clear", Q, 0);
            if (i < DEPTH) check_eq("ld_ready_clear", LD_READY, 0);
        end
        LD_START = 1'b0;
        model_clear();
        tick();
    endtask

    initial begin
        byte_q_t b;
        #12;
        check_eq("rst_busy", BUSY, 1);
        check_eq("rst_q", Q, 0);
        check_eq("rst_ovf", OVF, 0);
        check_eq("rst_ready", LD_READY, 0);
        check_eq("rst_misalign", MISALIGN, 0);
        check_eq("rst_perr", PERR, 0);
        @(negedge CLK);
        RESET_N = 1'b1;
        wait_clear();
        read_model(8'h10);

        b = '{8'hF0, 8'h01, 8'h21, 8'hF9};
        do_load(b, 0);
        read_expect("q_w0", 8'h00, 16'hF001, 1'b0);
        read_expect("q_w1", 8'h02, 16'h21F9, 1'b0);

        b = '{8'h12, 8'h34, 8'h56};
        do_load(b, 0);
        read_expect("q_w0b", 8'h00, 16'h1234, 1'b0);
        read_expect("q_partial", 8'h02, 16'h5600, 1'b0);
        read_expect("q_misalign", 8'h03, 16'h5600, 1'b1);
        read_expect("q_out_of_range", 8'h80, 16'h0000, 1'b0);

        for (int it = 0; it < 8; it++) begin
            b = {};
            repeat ($urandom_range(1, 24)) b.push_back(8'($urandom));
            do_load(b, 1);
            check_eq("ovf_none", OVF, model_ovf);
            repeat (6) read_model(8'($urandom_range(0, 255)));
        end

        b = {};
        repeat (2 * DEPTH + 2) b.push_back(8'($urandom));
        do_load(b, 1);
        check_eq("ovf_set", OVF, 1);
        read_expect("q_last_word", 8'(2 * (DEPTH - 1)), {b[2*DEPTH-2], b[2*DEPTH-1]}, 1'b0);
        read_model(8'($urandom_range(0, 2 * DEPTH - 1)));
        b = '{8'h5A};
        do_load(b, 0);
        check_eq("ovf_cleared", OVF, 0);
        read_expect("q_after_ovf", 8'h00, 16'h5A00, 1'b0);

        // Restart: AA is discarded, BB arrives with LD_START and is discarded too
        LD_START = 1'b1;
        tick();
        LD_START = 1'b0;
        LD_VALID = 1'b1; LD_BYTE = 8'hAA; tick();
        LD_START = 1'b1; LD_BYTE = 8'hBB; tick();
        LD_START = 1'b0; LD_BYTE = 8'hCC; tick();
        LD_BYTE = 8'hDD; LD_LAST = 1'b1; tick();
        LD_VALID = 1'b0; LD_LAST = 1'b0;
        tick();
        model_mem[0] = 16'hCCDD;
        read_expect("q_restart", 8'h00, 16'hCCDD, 1'b0);
        read_model(8'h02);

        b = '{8'h9E, 8'h37, 8'hC4, 8'h0B};
        do_load(b, 2);
        read_expect("q_bp0", 8'h00, 16'h9E37, 1'b0);
        read_expect("q_bp1", 8'h02, 16'hC40B, 1'b0);

`ifdef IMEM_PARITY_EN
        dut.mem[1][3] = ~dut.mem[1][3];
        ADDR = 8'h02;
        tick();
        check_eq("perr_flip", PERR, 1);
        read_expect("q_clean_w0", 8'h00, 16'h9E37, 1'b0);
`endif

        // Reset in the middle of a word aborts the load
        LD_START = 1'b1;
        tick();
        LD_START = 1'b0;
        LD_VALID = 1'b1; LD_BYTE = 8'h77; tick();
        LD_VALID = 1'b0;
        RESET_N = 1'b0;
        #1;
        check_eq("abort_q", Q, 0);
        check_eq("abort_busy", BUSY, 1);
        check_eq("abort_ready", LD_READY, 0);
        check_eq("abort_ovf", OVF, 0);
        @(negedge CLK);
        RESET_N = 1'b1;
        ADDR = 8'h00;
        wait_clear();
        read_expect("q_recleared0", 8'h00, 16'h0000, 1'b0);
        read_expect("q_recleared1", 8'h02, 16'h0000, 1'b0);
        repeat (4) read_model(8'($urandom_range(0, 255)));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
